// File: rtl/updown_display_pkg.sv
// Shared types, radix constants and the 7-segment glyph table for the up/down display counter.
package updown_display_pkg;

    localparam int RADIX_HEX = 16;
    localparam int RADIX_BCD = 10;

    typedef logic [3:0] nibble_t;

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input nibble_t n);
        logic [6:0] g;
        g = 7'h00;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/updown_display_counter_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, debouncer and one-cycle press pulse on 1->0.
// With AUTOREPEAT_EN defined, a held button also emits repeat pulses after a hold delay.
module btn_conditioner #(
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_dly;
    logic [DEB_W-1:0] deb_cnt;
    logic             rep_fire;

    // Levels reset to 1 so a button held through reset still produces one press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_dly <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            deb_dly <= deb;
            press   <= (deb_dly & ~deb) | rep_fire;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              repeating;

    // First wait HOLD_CYCLES, then fire once every REPEAT_CYCLES until release.
    always_ff @(posedge clk) begin
        if (!reset || deb) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (!repeating) begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                repeating <= 1'b1;
                hold_cnt  <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else if (hold_cnt == HOLD_W'(REPEAT_CYCLES - 1)) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign rep_fire = repeating && !deb && (hold_cnt == HOLD_W'(REPEAT_CYCLES - 1));
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/updown_display_counter.sv
// Multi-digit hex/BCD up/down counter with debounced buttons and a scanned 7-segment display.
// Optional auto-repeat on held buttons is built when AUTOREPEAT_EN is defined.
module updown_display_counter
    import updown_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int RADIX          = RADIX_HEX,
    parameter int DEB_CYCLES     = 50000,
    parameter int SCAN_CYCLES    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES  = 5_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_up,
    input  logic                btn_dn,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap,
    output logic [6:0]          seg7,
    output logic [DIGITS-1:0]   dig_sel
);

    localparam nibble_t DIGIT_MAX = nibble_t'(RADIX - 1);
    localparam int      IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int      ST_W      = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic                up_p;
    logic                dn_p;
    logic [4*DIGITS-1:0] count_inc;
    logic [4*DIGITS-1:0] count_dec;
    logic                carry;
    logic                borrow;
    logic [ST_W-1:0]     scan_timer;
    logic [IDX_W-1:0]    scan_idx;
    nibble_t             cur_nib;

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_cond_up (
        .clk(clk), .reset(reset), .btn(btn_up), .press(up_p)
    );

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_cond_dn (
        .clk(clk), .reset(reset), .btn(btn_dn), .press(dn_p)
    );

    // Ripple carry/borrow; a carry or borrow surviving past the top digit is a wrap.
    always_comb begin
        count_inc = count;
        count_dec = count;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == DIGIT_MAX) begin
                    count_inc[4*i +: 4] = '0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = DIGIT_MAX;
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (up_p && !dn_p) begin
                count <= count_inc;
                wrap  <= carry;
            end else if (dn_p && !up_p) begin
                count <= count_dec;
                wrap  <= borrow;
            end
        end
    end

    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) cur_nib = count[4*i +: 4];
        end
    end

    // seg7 and dig_sel are both registered from scan_idx, so they stay aligned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_timer <= '0;
            scan_idx   <= '0;
            seg7       <= glyph(4'h0) ^ {7{SEG_ACTIVE_LOW}};
            dig_sel    <= DIGITS'(1) ^ {DIGITS{SEG_ACTIVE_LOW}};
        end else begin
            if (scan_timer == ST_W'(SCAN_CYCLES - 1)) begin
                scan_timer <= '0;
                scan_idx   <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_timer <= scan_timer + 1'b1;
            end
            seg7    <= glyph(cur_nib) ^ {7{SEG_ACTIVE_LOW}};
            dig_sel <= (DIGITS'(1) << scan_idx) ^ {DIGITS{SEG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_updown_display_counter.sv
// Bench for updown_display_counter: a hex and a BCD instance share the same buttons.
module tb_updown_display_counter;
    localparam int DEB = 4;

    typedef struct {
        logic [7:0] cnt;
        logic       wrap;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b1;
    logic       btn_dn = 1'b1;
    logic [7:0] hex_count, bcd_count;
    logic       hex_wrap, bcd_wrap;
    logic [6:0] hex_seg, bcd_seg;
    logic [1:0] hex_dig, bcd_dig;

    logic [6:0] seg_0 = ~7'h3F;
    logic [6:0] seg_9 = ~7'h6F;
    logic [6:0] seg_f = ~7'h71;

    exp_t       hex_q[$];
    exp_t       bcd_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    logic [7:0] hex_prev = 8'h00;
    logic [7:0] bcd_prev = 8'h00;

    updown_display_counter #(
        .DIGITS(2), .RADIX(16), .DEB_CYCLES(DEB), .SCAN_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
    ) u_hex (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
        .count(hex_count), .wrap(hex_wrap), .seg7(hex_seg), .dig_sel(hex_dig)
    );

    updown_display_counter #(
        .DIGITS(2), .RADIX(10), .DEB_CYCLES(DEB), .SCAN_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
    ) u_bcd (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
        .count(bcd_count), .wrap(bcd_wrap), .seg7(bcd_seg), .dig_sel(bcd_dig)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitors: every count change pops one expected entry; stray wrap pulses are errors.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (hex_count !== hex_prev) begin
                if (hex_q.size() == 0) begin
                    check("hex_unexpected_change", {24'd0, hex_count}, {24'd0, hex_prev});
                end else begin
                    e = hex_q.pop_front();
                    check("hex_count", {24'd0, hex_count}, {24'd0, e.cnt});
                    check("hex_wrap", {31'd0, hex_wrap}, {31'd0, e.wrap});
                    if (e.due >= 0) check("hex_latency", cyc, e.due);
                end
                hex_prev = hex_count;
            end else if (hex_wrap !== 1'b0) begin
                check("hex_wrap_stray", {31'd0, hex_wrap}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bcd_count !== bcd_prev) begin
                if (bcd_q.size() == 0) begin
                    check("bcd_unexpected_change", {24'd0, bcd_count}, {24'd0, bcd_prev});
                end else begin
                    e = bcd_q.pop_front();
                    check("bcd_count", {24'd0, bcd_count}, {24'd0, e.cnt});
                    check("bcd_wrap", {31'd0, bcd_wrap}, {31'd0, e.wrap});
                    if (e.due >= 0) check("bcd_latency", cyc, e.due);
                end
                bcd_prev = bcd_count;
            end else if (bcd_wrap !== 1'b0) begin
                check("bcd_wrap_stray", {31'd0, bcd_wrap}, 32'd0);
            end
        end
    end

    // Driver: hold the buttons 10 cycles, release 10 cycles; push expected results when a change is due.
    task automatic press_step(input logic up, input logic dn,
                              input logic [7:0] eh, input logic ehw,
                              input logic [7:0] eb, input logic ebw, input bit change);
        @(negedge clk);
        btn_up = ~up;
        btn_dn = ~dn;
        if (change) begin
            hex_q.push_back('{eh, ehw, cyc + DEB + 4});
            bcd_q.push_back('{eb, ebw, cyc + DEB + 4});
        end
        repeat (10) @(negedge clk);
        btn_up = 1'b1;
        btn_dn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [1:0] d[8];
        logic [1:0] inv;
        logic [1:0] alt;

        // Reset held low for three cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hex_count", {24'd0, hex_count}, 32'h00);
        check("rst_hex_wrap", {31'd0, hex_wrap}, 32'd0);
        check("rst_hex_dig", {30'd0, hex_dig}, 32'b10);
        check("rst_hex_seg", {25'd0, hex_seg}, {25'd0, seg_0});
        check("rst_bcd_count", {24'd0, bcd_count}, 32'h00);
        check("rst_bcd_wrap", {31'd0, bcd_wrap}, 32'd0);
        check("rst_bcd_dig", {30'd0, bcd_dig}, 32'b10);
        check("rst_bcd_seg", {25'd0, bcd_seg}, {25'd0, seg_0});
        hex_prev = 8'h00;
        bcd_prev = 8'h00;
        mon_en = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Short glitch must be ignored
        btn_up = 1'b0;
        repeat (2) @(negedge clk);
        btn_up = 1'b1;
        repeat (20) @(negedge clk);

        // Three up presses
        press_step(1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1);
        press_step(1'b1, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0, 1'b1);
        press_step(1'b1, 1'b0, 8'h03, 1'b0, 8'h03, 1'b0, 1'b1);

        // Down through zero: wraps to all-F / all-9
        press_step(1'b0, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 1'b1);
        press_step(1'b0, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1);
        press_step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        press_step(1'b0, 1'b1, 8'hFF, 1'b1, 8'h99, 1'b1, 1'b1);

        // Display scan: every digit shows F (hex) / 9 (BCD), digit select alternates every 2 cycles
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d[i] = hex_dig;
            check("scan_hex_seg", {25'd0, hex_seg}, {25'd0, seg_f});
            check("scan_bcd_seg", {25'd0, bcd_seg}, {25'd0, seg_9});
            inv = ~hex_dig;
            check("scan_dig_onehot", $countones(inv), 32'd1);
        end
        for (int i = 0; i < 6; i++) begin
            alt = ~d[i];
            check("scan_dig_period", {30'd0, d[i+2]}, {30'd0, alt});
        end

        // Up from all-max wraps to zero
        press_step(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);

        // Count to 9, then the BCD instance carries into the tens digit
        for (int i = 1; i <= 9; i++) begin
            press_step(1'b1, 1'b0, 8'(i), 1'b0, 8'(i), 1'b0, 1'b1);
        end
        press_step(1'b1, 1'b0, 8'h0A, 1'b0, 8'h10, 1'b0, 1'b1);
        press_step(1'b0, 1'b1, 8'h09, 1'b0, 8'h09, 1'b0, 1'b1);
        press_step(1'b1, 1'b0, 8'h0A, 1'b0, 8'h10, 1'b0, 1'b1);

        // Both buttons together: no change
        press_step(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Hold up for 50 cycles
        @(negedge clk);
        btn_up = 1'b0;
        hex_q.push_back('{8'h0B, 1'b0, cyc + DEB + 4});
        bcd_q.push_back('{8'h11, 1'b0, cyc + DEB + 4});
`ifdef AUTOREPEAT_EN
        hex_q.push_back('{8'h0C, 1'b0, -1});
        hex_q.push_back('{8'h0D, 1'b0, -1});
        hex_q.push_back('{8'h0E, 1'b0, -1});
        bcd_q.push_back('{8'h12, 1'b0, -1});
        bcd_q.push_back('{8'h13, 1'b0, -1});
        bcd_q.push_back('{8'h14, 1'b0, -1});
`endif
        repeat (50) @(negedge clk);
        btn_up = 1'b1;
        repeat (40) @(negedge clk);

        // Every expected event must have been seen
        check("hex_queue_drained", hex_q.size(), 32'd0);
        check("bcd_queue_drained", bcd_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
